// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared opcode encoding and helpers for the pipelined barrel shifter.
package pipelined_barrel_shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return op > OP_ROR;
  endfunction

  // Left-moving ops take their carry from the top of the operand.
  function automatic logic shifts_left(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/bs_mux_level.sv
// One combinational level of the log2 shift network: moves data by SHIFT_BY when en is set.
module bs_mux_level
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHIFT_BY   = 1
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  en,
  input  logic [OP_W-1:0]       op,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic [DATA_WIDTH-1:0] moved;

  always_comb begin
    // NOTE: default assignment first, so every path assigns moved and no latch is inferred.
    moved = data;
    case (op)
      OP_SLL:  moved = data << SHIFT_BY;
      OP_SRL:  moved = data >> SHIFT_BY;
      OP_SRA:  moved = $signed(data) >>> SHIFT_BY;
      OP_ROL:  moved = {data[DATA_WIDTH-SHIFT_BY-1:0], data[DATA_WIDTH-1:DATA_WIDTH-SHIFT_BY]};
      OP_ROR:  moved = {data[SHIFT_BY-1:0], data[DATA_WIDTH-1:SHIFT_BY]};
      default: moved = data;
    endcase
  end

  assign shifted = en ? moved : data;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit: log2 mux network split into register stages,
// with a global-stall valid/ready handshake on both sides.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter  int DATA_WIDTH       = 32,
  parameter  int LEVELS_PER_STAGE = 2,
  localparam int SHIFT_W          = $clog2(DATA_WIDTH),
  localparam int NUM_STAGES       = (SHIFT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SHIFT_W-1:0]    in_amt,
  input  logic [OP_W-1:0]       in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_carry,
  output logic                  out_zero,
  output logic                  out_err
);

  localparam int CTL_N = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  // Stage register banks; the last bank is the output register.
  logic [DATA_WIDTH-1:0] st_data  [NUM_STAGES];
  logic                  st_valid [NUM_STAGES];
  logic                  st_carry [NUM_STAGES];
  logic                  st_err   [NUM_STAGES];
  logic                  zero_q;
  logic [SHIFT_W-1:0]    ctl_amt  [CTL_N];
  logic [OP_W-1:0]       ctl_op   [CTL_N];

  logic [DATA_WIDTH-1:0] data_src  [NUM_STAGES];
  logic [SHIFT_W-1:0]    amt_src   [NUM_STAGES];
  logic [OP_W-1:0]       op_src    [NUM_STAGES];
  logic                  valid_src [NUM_STAGES];
  logic                  carry_src [NUM_STAGES];
  logic                  err_src   [NUM_STAGES];
  logic [DATA_WIDTH-1:0] stage_res [NUM_STAGES];
  logic [DATA_WIDTH-1:0] lvl_out   [SHIFT_W];

  logic               stall;
  logic               carry0;
  logic [SHIFT_W-1:0] neg_amt;
  logic [SHIFT_W-1:0] amt_m1;

  assign stall    = st_valid[NUM_STAGES-1] && !out_ready;
  assign in_ready = !stall;

  // W-k and k-1 are the operand bits that leave last for left and right moves.
  assign neg_amt = -in_amt;
  assign amt_m1  = in_amt - SHIFT_W'(1);

  always_comb begin
    carry0 = 1'b0;
    if (in_amt != '0 && !is_reserved(in_op)) begin
      carry0 = shifts_left(in_op) ? in_data[neg_amt] : in_data[amt_m1];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int END_LVL = ((s + 1) * LEVELS_PER_STAGE < SHIFT_W)
                             ? (s + 1) * LEVELS_PER_STAGE : SHIFT_W;
    if (s == 0) begin : g_first
      assign data_src[s]  = in_data;
      assign amt_src[s]   = in_amt;
      assign op_src[s]    = in_op;
      assign valid_src[s] = in_valid;
      assign carry_src[s] = carry0;
      assign err_src[s]   = is_reserved(in_op);
    end else begin : g_next
      assign data_src[s]  = st_data[s-1];
      assign amt_src[s]   = ctl_amt[s-1];
      assign op_src[s]    = ctl_op[s-1];
      assign valid_src[s] = st_valid[s-1];
      assign carry_src[s] = st_carry[s-1];
      assign err_src[s]   = st_err[s-1];
    end
    assign stage_res[s] = lvl_out[END_LVL-1];
  end

  // Amount bits are consumed LSB-first; each stage hands the rest on right-aligned.
  for (genvar i = 0; i < SHIFT_W; i++) begin : g_lvl
    localparam int STG = i / LEVELS_PER_STAGE;
    localparam int POS = i % LEVELS_PER_STAGE;
    logic [DATA_WIDTH-1:0] lvl_in;
    if (POS == 0) begin : g_head
      assign lvl_in = data_src[STG];
    end else begin : g_chain
      assign lvl_in = lvl_out[i-1];
    end
    bs_mux_level #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHIFT_BY   (1 << i)
    ) u_level (
      .data    (lvl_in),
      .en      (amt_src[STG][POS]),
      .op      (op_src[STG]),
      .shifted (lvl_out[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well as valids so outputs never show X.
      for (int s = 0; s < NUM_STAGES; s++) begin
        st_valid[s] <= 1'b0;
        st_data[s]  <= '0;
        st_carry[s] <= 1'b0;
        st_err[s]   <= 1'b0;
      end
      for (int c = 0; c < CTL_N; c++) begin
        ctl_amt[c] <= '0;
        ctl_op[c]  <= '0;
      end
      zero_q <= 1'b0;
    end else if (!stall) begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      for (int s = 0; s < NUM_STAGES; s++) begin
        st_valid[s] <= valid_src[s];
        st_data[s]  <= stage_res[s];
        st_carry[s] <= carry_src[s];
        st_err[s]   <= err_src[s];
      end
      for (int c = 0; c < NUM_STAGES - 1; c++) begin
        ctl_amt[c] <= amt_src[c] >> LEVELS_PER_STAGE;
        ctl_op[c]  <= op_src[c];
      end
      zero_q <= (stage_res[NUM_STAGES-1] == '0);
    end
  end

  assign out_valid = st_valid[NUM_STAGES-1];
  assign out_data  = st_data[NUM_STAGES-1];
  assign out_carry = st_carry[NUM_STAGES-1];
  assign out_err   = st_err[NUM_STAGES-1];
  assign out_zero  = zero_q;

endmodule
